systolic_ctrl: RTL and testbench

SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

---
 rtl/systolic_pkg.sv | 16 +
 rtl/systolic_ctrl_skew_shift.sv | 28 ++
 rtl/systolic_ctrl.sv | 158 +++++++++++++++
 tb/tb_systolic_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and default sizing for the systolic array controller and array top level.
package systolic_pkg;

  localparam int unsigned N_DEF  = 4;
  localparam int unsigned LW_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    WAIT_W,
    STREAM,
    DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/systolic_ctrl_skew_shift.sv
// Reset-clearable 1-bit shift register; taps[k] is din delayed k+1 cycles.
module skew_shift #(
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  output logic [DEPTH-1:0] taps
);

  logic [DEPTH-1:0] sr_q;
  logic [DEPTH-1:0] sr_d;

  always_comb begin
    sr_d = {sr_q[DEPTH-2:0], din};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign taps = sr_q;

endmodule

// File: rtl/systolic_ctrl.sv
// Systolic array sequencer: weight load, activation stream, drain, done pulse.
// Define SYSTOLIC_CTRL_PERF_EN to add the cycle_cnt busy-cycle counter port.
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter int unsigned N  = N_DEF,
  parameter int unsigned LW = LW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [LW-1:0] m_len,
  output logic          busy,
  output logic          w_rd_en,
  output logic [N-1:0]  wt_en,
  output logic          a_rd_en,
  output logic [N-1:0]  valid_in,
  output logic [N-1:0]  out_valid,
  output logic          done
`ifdef SYSTOLIC_CTRL_PERF_EN
  ,
  output logic [31:0]   cycle_cnt
`endif
);

  localparam int unsigned PW = $clog2(2 * N);
  localparam int unsigned SW = 2 * N;

  state_e          state_q, state_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic [LW-1:0]   len_q, len_d;
  logic            busy_q, busy_d;
  logic            w_rd_en_q, w_rd_en_d;
  logic            a_rd_en_q, a_rd_en_d;
  logic            done_q, done_d;
  logic [N-1:0]    wt_en_q, wt_en_d;
  logic [SW-1:0]   skew_taps;

  // Next state; outputs are decoded from the next state so they register in step with it.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    len_d   = len_q;
    wt_en_d = '0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          len_d   = m_len;
          phase_d = '0;
          state_d = LOAD_W;
        end
      end
      LOAD_W: begin
        wt_en_d = N'(1) << phase_q;
        if (phase_q == PW'(N - 1)) begin
          phase_d = '0;
          state_d = WAIT_W;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      WAIT_W: begin
        state_d = (len_q != '0) ? STREAM : DONE;
      end
      STREAM: begin
        len_d = len_q - LW'(1);
        if (len_q == LW'(1)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (phase_q == PW'(2 * N - 1)) begin
          phase_d = '0;
          state_d = DONE;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d    = (state_d != IDLE);
    w_rd_en_d = (state_d == LOAD_W);
    a_rd_en_d = (state_d == STREAM);
    done_d    = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      len_q     <= '0;
      busy_q    <= 1'b0;
      w_rd_en_q <= 1'b0;
      a_rd_en_q <= 1'b0;
      done_q    <= 1'b0;
      wt_en_q   <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      len_q     <= len_d;
      busy_q    <= busy_d;
      w_rd_en_q <= w_rd_en_d;
      a_rd_en_q <= a_rd_en_d;
      done_q    <= done_d;
      wt_en_q   <= wt_en_d;
    end
  end

  // Row skew taps 0..N-1 feed valid_in; taps N..2N-1 give the bottom-edge result valids.
  skew_shift #(
    .DEPTH(SW)
  ) u_skew (
    .clk (clk),
    .rst (rst),
    .din (a_rd_en_q),
    .taps(skew_taps)
  );

  assign busy      = busy_q;
  assign w_rd_en   = w_rd_en_q;
  assign wt_en     = wt_en_q;
  assign a_rd_en   = a_rd_en_q;
  assign done      = done_q;
  assign valid_in  = skew_taps[N-1:0];
  assign out_valid = skew_taps[SW-1:N];

`ifdef SYSTOLIC_CTRL_PERF_EN
  localparam int unsigned CW = 32;

  logic [CW-1:0] cycle_cnt_q, cycle_cnt_d;

  // Saturating busy-cycle count, restarted on job acceptance.
  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    if (state_q == IDLE && start) begin
      cycle_cnt_d = '0;
    end else if (busy_q && (cycle_cnt_q != '1)) begin
      cycle_cnt_d = cycle_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// Randomized bench for systolic_ctrl against a job-timeline reference model.
module tb_systolic_ctrl;

  localparam int N    = 4;
  localparam int LW   = 8;
  localparam int MAXC = 16384;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [LW-1:0] m_len;
  logic          busy, w_rd_en, a_rd_en, done;
  logic [N-1:0]  wt_en, valid_in, out_valid;
`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [31:0]   cycle_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state: one job at most, described by acceptance cycle and length.
  int cyc = 0;
  bit job_v = 1'b0;
  int t0 = 0;
  int jm = 0;
  int jl = 0;
  int perf_prev = 0;
  int a_cnt = 0;
  bit a_hist [MAXC];

  always #5 clk = ~clk;

  systolic_ctrl #(
    .N (N),
    .LW(LW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .m_len    (m_len),
    .busy     (busy),
    .w_rd_en  (w_rd_en),
    .wt_en    (wt_en),
    .a_rd_en  (a_rd_en),
    .valid_in (valid_in),
    .out_valid(out_valid),
    .done     (done)
`ifdef SYSTOLIC_CTRL_PERF_EN
    ,
    .cycle_cnt(cycle_cnt)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit hist(input int t);
    return (t < 0) ? 1'b0 : a_hist[t];
  endfunction

  function automatic bit model_idle(input int c);
    return !job_v || ((c - t0) > jl);
  endfunction

  function automatic int exp_perf(input int c);
    int k;
    if (!job_v) return perf_prev;
    k = c - t0;
    if (k < 1) return perf_prev;
    return ((k - 1) < jl) ? (k - 1) : jl;
  endfunction

  // Compare every output for cycle cyc against the job timeline.
  task automatic check_cycle();
    int k;
    logic bz, wr, ar, dn;
    logic [N-1:0] we, vi, ov;
    bz = 1'b0; wr = 1'b0; ar = 1'b0; dn = 1'b0; we = '0;
    if (job_v) begin
      k  = cyc - t0;
      bz = (k >= 1) && (k <= jl);
      wr = (k >= 1) && (k <= N);
      if (k >= 2 && k <= N + 1) we[k-2] = 1'b1;
      ar = (k >= N + 2) && (k <= N + 1 + jm);
      dn = (k == jl);
    end
    a_hist[cyc] = ar;
    for (int i = 0; i < N; i++) begin
      vi[i] = hist(cyc - 1 - i);
      ov[i] = hist(cyc - N - 1 - i);
    end
    if (a_rd_en === 1'b1) a_cnt++;
    check_val("busy",      32'(busy),      32'(bz));
    check_val("w_rd_en",   32'(w_rd_en),   32'(wr));
    check_val("wt_en",     32'(wt_en),     32'(we));
    check_val("a_rd_en",   32'(a_rd_en),   32'(ar));
    check_val("valid_in",  32'(valid_in),  32'(vi));
    check_val("out_valid", 32'(out_valid), 32'(ov));
    check_val("done",      32'(done),      32'(dn));
`ifdef SYSTOLIC_CTRL_PERF_EN
    check_val("cycle_cnt", cycle_cnt, 32'(exp_perf(cyc)));
`endif
  endtask

  task automatic step(input bit s, input int m);
    @(negedge clk);
    check_cycle();
    start = s;
    m_len = LW'(m);
    if (s && model_idle(cyc)) begin
      perf_prev = exp_perf(cyc);
      job_v = 1'b1;
      t0 = cyc;
      jm = m;
      jl = (m > 0) ? (3 * N + 2 + m) : (N + 2);
    end
    cyc++;
  endtask

  // Assert rst mid-cycle; outputs must clear before the next clock edge.
  task automatic do_reset(input int hold);
    @(negedge clk);
    check_cycle();
    rst   = 1'b1;
    start = 1'b0;
    #1;
    job_v = 1'b0;
    perf_prev = 0;
    for (int t = 0; t <= cyc; t++) a_hist[t] = 1'b0;
    check_cycle();
    cyc++;
    repeat (hold) begin
      @(negedge clk);
      check_cycle();
      cyc++;
    end
    rst = 1'b0;
  endtask

  initial begin
    int r;
    rst   = 1'b1;
    start = 1'b0;
    m_len = '0;
    do_reset(2);
    repeat (3) step(1'b0, 0);

    // Reference timeline job, then the zero-length job.
    step(1'b1, 3);
    repeat (20) step(1'b0, 0);
    step(1'b1, 0);
    repeat (10) step(1'b0, 0);

    // start held high: back-to-back jobs, restarts ignored while busy.
    for (int j = 0; j < 160; j++) step(1'b1, $urandom_range(0, 6));
    repeat (40) step(1'b0, 0);

    // Abort during STREAM, then a clean job.
    step(1'b1, 20);
    repeat (N + 4) step(1'b0, 0);
    do_reset(2);
    step(1'b1, 3);
    repeat (20) step(1'b0, 0);

    // Longest stream: counter must not wrap into an extra strobe.
    a_cnt = 0;
    step(1'b1, 255);
    repeat (300) step(1'b0, 0);
    check_val("a_cnt_255", 32'(a_cnt), 32'd255);
`ifdef SYSTOLIC_CTRL_PERF_EN
    check_val("perf_255", cycle_cnt, 32'(255 + 3 * N + 2));
`endif

    // Random starts, lengths and occasional resets.
    for (int j = 0; j < 3000; j++) begin
      r = $urandom_range(0, 99);
      if (r < 2) do_reset($urandom_range(1, 3));
      else step(r < 30, (r < 5) ? 0 : $urandom_range(0, 12));
    end
    repeat (60) step(1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
